// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues synchronous-read addresses and
// hands one instruction per cycle to the decoder, with LUT-based branch redirect.
module fetch_unit #(
    parameter int unsigned        PC_W      = 10,
    parameter int unsigned        INSTR_W   = 9,
    parameter int unsigned        LUT_AW    = 5,
    parameter logic [INSTR_W-1:0] HALT_WORD = 9'h1FF
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start_i,
    output logic               Done_o,
    output logic [PC_W-1:0]    InstAddr_o,
    input  logic [INSTR_W-1:0] InstData_i,
    output logic [INSTR_W-1:0] Instr_o,
    output logic               InstrValid_o,
    input  logic               Branch_i,
    input  logic               Taken_i,
    input  logic               LutWe_i,
    input  logic [LUT_AW-1:0]  LutAddr_i,
    input  logic [PC_W-1:0]    LutData_i,
    output logic [15:0]        InstrCount_o
);

    localparam int unsigned LUT_DEPTH = 1 << LUT_AW;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              pending_q, pending_d;
    logic              done_q, done_d;
    logic [15:0]       count_q, count_d;
    logic [PC_W-1:0]   lut_q [LUT_DEPTH];
    logic [PC_W-1:0]   lut_d [LUT_DEPTH];

    logic              instr_valid;
    logic              halt_hit;
    logic              branch_hit;
    logic [LUT_AW-1:0] lut_idx;

    // pending marks that the word returning this cycle belongs to the live stream
    assign instr_valid = (state_q == RUN) && pending_q;
    assign halt_hit    = instr_valid && (InstData_i == HALT_WORD);
    assign branch_hit  = instr_valid && Branch_i && Taken_i;
    assign lut_idx     = InstData_i[LUT_AW-1:0];

    always_comb begin
        lut_d = lut_q;
        if (LutWe_i && (state_q != RUN)) begin
            lut_d[LutAddr_i] = LutData_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        done_d    = done_q;
        count_d   = count_q;
        unique case (state_q)
            RUN: begin
                if (instr_valid && (count_q != 16'hFFFF)) begin
                    count_d = count_q + 16'd1;
                end
                if (Start_i) begin
                    pc_d      = '0;
                    pending_d = 1'b0;
                    count_d   = '0;
                end else if (halt_hit) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    pending_d = 1'b0;
                end else if (branch_hit) begin
                    // sequential word already in flight is discarded via pending
                    pc_d      = lut_q[lut_idx];
                    pending_d = 1'b0;
                end else begin
                    pc_d      = pc_q + PC_W'(1);
                    pending_d = 1'b1;
                end
            end
            default: begin
                if (Start_i) begin
                    state_d   = RUN;
                    pc_d      = '0;
                    pending_d = 1'b0;
                    count_d   = '0;
                    done_d    = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
            for (int i = 0; i < int'(LUT_DEPTH); i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            count_q   <= count_d;
            lut_q     <= lut_d;
        end
    end

    assign Done_o       = done_q;
    assign InstAddr_o   = pc_q;
    assign Instr_o      = InstData_i;
    assign InstrValid_o = instr_valid;
    assign InstrCount_o = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a fetch-stream reference model (issued address, whether
// the returning fetch is live, retired count) checked every cycle, plus directed runs.
module tb_fetch_unit;

    localparam logic [8:0] HALT   = 9'h1FF;
    localparam int         M_IDLE = 0;
    localparam int         M_RUN  = 1;
    localparam int         M_DONE = 2;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        done;
    logic [9:0]  inst_addr;
    logic [8:0]  inst_data;
    logic [8:0]  instr;
    logic        instr_valid;
    logic        branch;
    logic        taken;
    logic        lut_we;
    logic [4:0]  lut_addr;
    logic [9:0]  lut_data;
    logic [15:0] instr_count;

    logic [8:0]  mem [1024];

    fetch_unit #(
        .PC_W     (10),
        .INSTR_W  (9),
        .LUT_AW   (5),
        .HALT_WORD(9'h1FF)
    ) dut (
        .Clk         (clk),
        .Reset_n     (reset_n),
        .Start_i     (start),
        .Done_o      (done),
        .InstAddr_o  (inst_addr),
        .InstData_i  (inst_data),
        .Instr_o     (instr),
        .InstrValid_o(instr_valid),
        .Branch_i    (branch),
        .Taken_i     (taken),
        .LutWe_i     (lut_we),
        .LutAddr_i   (lut_addr),
        .LutData_i   (lut_data),
        .InstrCount_o(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) inst_data <= mem[inst_addr];

    // reference model state
    int         m_state;
    logic [9:0] m_pc;
    logic [9:0] m_prev;
    bit         m_live;
    bit         m_done;
    int         m_count;
    logic [9:0] m_lut [32];

    int         n_checks;
    int         n_pass;
    int         br_mode;
    logic [9:0] br_addr;
    bit         seen3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic bit model_valid();
        return (m_state == M_RUN) && m_live;
    endfunction

    task automatic model_edge();
        logic [8:0] cur;
        bit         v;
        if (!reset_n) begin
            m_state = M_IDLE;
            m_pc    = '0;
            m_prev  = '0;
            m_live  = 0;
            m_done  = 0;
            m_count = 0;
            for (int i = 0; i < 32; i++) m_lut[i] = '0;
            return;
        end
        v      = model_valid();
        cur    = mem[m_prev];
        m_prev = m_pc;
        if (m_state != M_RUN && lut_we) m_lut[lut_addr] = lut_data;
        if (m_state != M_RUN) begin
            if (start) begin
                m_state = M_RUN;
                m_pc    = '0;
                m_live  = 0;
                m_count = 0;
                m_done  = 0;
            end
        end else begin
            if (v && m_count < 65535) m_count++;
            if (start) begin
                m_pc    = '0;
                m_live  = 0;
                m_count = 0;
            end else if (v && cur == HALT) begin
                m_state = M_DONE;
                m_done  = 1;
                m_live  = 0;
            end else if (v && branch && taken) begin
                m_pc   = m_lut[cur[4:0]];
                m_live = 0;
            end else begin
                m_pc   = m_pc + 10'd1;
                m_live = 1;
            end
        end
    endtask

    // called at a negedge: drive branch inputs, clock one edge, then compare
    task automatic cycle();
        bit v;
        v = model_valid();
        case (br_mode)
            1: begin branch = v && (m_prev == br_addr); taken = branch; end
            2: begin branch = v && (m_prev == br_addr); taken = 1'b0; end
            3: begin branch = ($urandom_range(0, 2) == 0); taken = $urandom_range(0, 1) == 1; end
            default: begin branch = 1'b0; taken = 1'b0; end
        endcase
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("addr", inst_addr, m_pc);
        check("valid", instr_valid, model_valid());
        check("done", done, m_done);
        check("count", instr_count, m_count);
        if (model_valid()) check("instr", instr, mem[m_prev]);
        if (instr_valid === 1'b1 && m_prev == 10'd3) seen3 = 1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic lut_write(input logic [4:0] a, input logic [9:0] d);
        lut_we   = 1'b1;
        lut_addr = a;
        lut_data = d;
        cycle();
        lut_we   = 1'b0;
    endtask

    task automatic run_to_done(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            cycle();
            cycles++;
        end
        check("run_done", done, 1'b1);
    endtask

    task automatic fill_mem_no_halt();
        for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom_range(0, 9'h1FE));
    endtask

    int cyc;
    int n;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        br_mode  = 0;
        br_addr  = '0;
        seen3    = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        branch   = 1'b0;
        taken    = 1'b0;
        lut_we   = 1'b0;
        lut_addr = '0;
        lut_data = '0;
        fill_mem_no_halt();

        // reset
        repeat (3) cycle();
        reset_n = 1'b1;
        cycle();
        check("rst_addr", inst_addr, 10'd0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_count", instr_count, 16'd0);

        // straight-line: 5 ALU words then halt at 5
        mem[5] = HALT;
        pulse_start();
        run_to_done(50, cyc);
        check("straight_cycles", cyc, 7);
        check("straight_count", instr_count, 16'd6);
        repeat (3) cycle();
        check("done_holds", done, 1'b1);

        // taken branch via LUT[3]=20
        mem[2]  = 9'h003;
        mem[20] = 9'h0A4;
        mem[21] = HALT;
        lut_write(5'd3, 10'd20);
        br_mode = 1;
        br_addr = 10'd2;
        seen3   = 0;
        pulse_start();
        run_to_done(50, cyc);
        check("taken_cycles", cyc, 7);
        check("taken_count", instr_count, 16'd5);
        check("addr3_squashed", seen3, 1'b0);

        // same program, not taken
        br_mode = 2;
        pulse_start();
        run_to_done(50, cyc);
        check("nottaken_cycles", cyc, 7);
        check("nottaken_count", instr_count, 16'd6);

        // restart at PC=7, LUT write in RUN ignored
        br_mode = 0;
        mem[5]  = 9'h012;
        mem[12] = HALT;
        pulse_start();
        n = 0;
        while (inst_addr !== 10'd7 && n < 40) begin
            cycle();
            n++;
        end
        check("reach_pc7", inst_addr, 10'd7);
        lut_we   = 1'b1;
        lut_addr = 5'd3;
        lut_data = 10'd99;
        start    = 1'b1;
        cycle();
        start    = 1'b0;
        lut_we   = 1'b0;
        check("restart_addr", inst_addr, 10'd0);
        check("restart_count", instr_count, 16'd0);
        run_to_done(50, cyc);
        check("restart_count_end", instr_count, 16'd13);
        mem[12] = 9'h033;
        mem[5]  = HALT;
        br_mode = 1;
        seen3   = 0;
        pulse_start();
        run_to_done(50, cyc);
        check("lut_unchanged_count", instr_count, 16'd5);
        check("lut_unchanged_squash", seen3, 1'b0);

        // wrap with no halt, then reset mid-run
        br_mode = 0;
        fill_mem_no_halt();
        pulse_start();
        repeat (1040) cycle();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        check("midrst_addr", inst_addr, 10'd0);
        check("midrst_valid", instr_valid, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_count", instr_count, 16'd0);

        // randomized runs
        br_mode = 3;
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < 1024; i++)
                mem[i] = ($urandom_range(0, 39) == 0) ? HALT : 9'($urandom_range(0, 9'h1FE));
            for (int j = 0; j < 4; j++) lut_write(5'($urandom), 10'($urandom));
            pulse_start();
            for (int c = 0; c < 200; c++) begin
                start    = ($urandom_range(0, 99) == 0);
                reset_n  = ($urandom_range(0, 499) != 0);
                lut_we   = ($urandom_range(0, 9) == 0);
                lut_addr = 5'($urandom);
                lut_data = 10'($urandom);
                cycle();
            end
            start   = 1'b0;
            lut_we  = 1'b0;
            reset_n = 1'b0;
            cycle();
            reset_n = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
